pong_game_ctrl: RTL and testbench

//  Game-sequencing controller for the VGA Pong datapath. Runs the match FSM (idle, serve, play, pause,

---
 rtl/pong_game_ctrl_pkg.sv | 33 +++
 rtl/pong_game_ctrl_if.sv | 25 ++
 rtl/pong_game_ctrl_btn_sync_edge.sv | 24 ++
 rtl/pong_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// Shared game definitions for the Pong match controller: state encoding,
// default timing constants used by the top level, and a small divider helper.
package pong_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_POINT    = 3'd4,
    ST_GAMEOVER = 3'd5
  } game_state_e;

  localparam int DEF_SPEED_DIV    = 12;
  localparam int DEF_SPEED_MIN    = 4;
  localparam int DEF_ACCEL_HITS   = 3;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 30;
  localparam int DEF_WIN_SCORE    = 9;

  localparam int CNT_W = 8;

  // One step faster, but never below the floor.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] floor_val);
    if (val > floor_val) begin
      sat_dec = val - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_dec = floor_val;
    end
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Game-event bus between the VGA timing/movement blocks and the match controller.
interface pong_game_ctrl_if;
  logic       frame_start;
  logic       pause_btn;
  logic       goal1;
  logic       goal2;
  logic       hit;
  logic       move_tick;
  logic       restart;
  logic [3:0] point1;
  logic [3:0] point2;
  logic       paused;
  logic       game_over;
  logic       winner;

  modport master (
    output frame_start, pause_btn, goal1, goal2, hit,
    input  move_tick, restart, point1, point2, paused, game_over, winner
  );

  modport slave (
    input  frame_start, pause_btn, goal1, goal2, hit,
    output move_tick, restart, point1, point2, paused, game_over, winner
  );
endinterface

// File: rtl/pong_game_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for a raw push button followed by a rising-edge detector,
// producing a single-cycle press pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic press
);
  logic [1:0] sync_r;
  logic       prev_r;

  // Synchronizer chain plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], btn_async};
      prev_r <= sync_r[1];
    end
  end

  assign press = sync_r[1] & ~prev_r;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: match FSM, score registers, per-frame move tick with
// rally acceleration, and the ball/bar restart level.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int SPEED_DIV    = DEF_SPEED_DIV,
  parameter int SPEED_MIN    = DEF_SPEED_MIN,
  parameter int ACCEL_HITS   = DEF_ACCEL_HITS,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic             ClockK,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_START  = CNT_W'(SPEED_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN    = CNT_W'(SPEED_MIN);
  localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(ACCEL_HITS - 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN_PTS    = 4'(WIN_SCORE);

  game_state_e      state_r, state_s;
  logic [CNT_W-1:0] frame_cnt_r, frame_cnt_s;
  logic [CNT_W-1:0] div_r, div_s;
  logic [CNT_W-1:0] hit_cnt_r, hit_cnt_s;
  logic [3:0]       point1_r, point1_s;
  logic [3:0]       point2_r, point2_s;
  logic             winner_r, winner_s;
  logic             restart_r, paused_r, game_over_r;
  logic             move_tick_s;
  logic             press_s;

  btn_sync_edge u_pause_sync (
    .clk       (ClockK),
    .rst_n     (reset),
    .btn_async (bus.pause_btn),
    .press     (press_s)
  );

  // Next-state, counter, divider and score logic.
  always_comb begin
    state_s     = state_r;
    frame_cnt_s = frame_cnt_r;
    div_s       = div_r;
    hit_cnt_s   = hit_cnt_r;
    point1_s    = point1_r;
    point2_s    = point2_r;
    winner_s    = winner_r;
    move_tick_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_s) state_s = ST_SERVE;
        else         state_s = ST_IDLE;
      end
      ST_SERVE: begin
        if (bus.frame_start && (frame_cnt_r >= SERVE_LAST)) begin
          state_s     = ST_PLAY;
          frame_cnt_s = '0;
        end else if (bus.frame_start) begin
          frame_cnt_s = frame_cnt_r + CNT_ONE;
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      ST_PLAY: begin
        // >= keeps the wrap safe when the divider shrinks mid-count.
        if (bus.frame_start && (frame_cnt_r >= (div_r - CNT_ONE))) begin
          move_tick_s = 1'b1;
          frame_cnt_s = '0;
        end else if (bus.frame_start) begin
          frame_cnt_s = frame_cnt_r + CNT_ONE;
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
        if (bus.goal1) begin
          point1_s    = point1_r + 4'd1;
          frame_cnt_s = '0;
          if (point1_s == WIN_PTS) begin
            state_s  = ST_GAMEOVER;
            winner_s = 1'b0;
          end else begin
            state_s = ST_POINT;
          end
        end else if (bus.goal2) begin
          point2_s    = point2_r + 4'd1;
          frame_cnt_s = '0;
          if (point2_s == WIN_PTS) begin
            state_s  = ST_GAMEOVER;
            winner_s = 1'b1;
          end else begin
            state_s = ST_POINT;
          end
        end else begin
          if (bus.hit && (hit_cnt_r >= HIT_LAST)) begin
            hit_cnt_s = '0;
            div_s     = sat_dec(div_r, DIV_MIN);
          end else if (bus.hit) begin
            hit_cnt_s = hit_cnt_r + CNT_ONE;
          end else begin
            hit_cnt_s = hit_cnt_r;
          end
          if (press_s) state_s = ST_PAUSED;
          else         state_s = ST_PLAY;
        end
      end
      ST_PAUSED: begin
        if (press_s) state_s = ST_PLAY;
        else         state_s = ST_PAUSED;
      end
      ST_POINT: begin
        if (bus.frame_start && (frame_cnt_r >= POINT_LAST)) begin
          state_s = ST_SERVE;
        end else if (bus.frame_start) begin
          frame_cnt_s = frame_cnt_r + CNT_ONE;
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      ST_GAMEOVER: begin
        if (press_s) begin
          state_s  = ST_SERVE;
          point1_s = 4'd0;
          point2_s = 4'd0;
        end else begin
          state_s = ST_GAMEOVER;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Every serve starts from the slow speed with a fresh rally.
    if ((state_s == ST_SERVE) && (state_r != ST_SERVE)) begin
      div_s       = DIV_START;
      hit_cnt_s   = '0;
      frame_cnt_s = '0;
    end else begin
      div_s = div_s;
    end
  end

  // Match state register.
  always_ff @(posedge ClockK or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters, scores and registered status outputs.
  always_ff @(posedge ClockK or negedge reset) begin
    if (!reset) begin
      frame_cnt_r <= '0;
      div_r       <= DIV_START;
      hit_cnt_r   <= '0;
      point1_r    <= 4'd0;
      point2_r    <= 4'd0;
      winner_r    <= 1'b0;
      restart_r   <= 1'b1;
      paused_r    <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      frame_cnt_r <= frame_cnt_s;
      div_r       <= div_s;
      hit_cnt_r   <= hit_cnt_s;
      point1_r    <= point1_s;
      point2_r    <= point2_s;
      winner_r    <= winner_s;
      restart_r   <= (state_s == ST_IDLE) || (state_s == ST_SERVE) || (state_s == ST_GAMEOVER);
      paused_r    <= (state_s == ST_PAUSED);
      game_over_r <= (state_s == ST_GAMEOVER);
    end
  end

  // The tick must land on the frame_start cycle itself, so it stays combinational.
  assign bus.move_tick = move_tick_s;
  assign bus.restart   = restart_r;
  assign bus.point1    = point1_r;
  assign bus.point2    = point2_r;
  assign bus.paused    = paused_r;
  assign bus.game_over = game_over_r;
  assign bus.winner    = winner_r;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed match scenarios with randomized
// frame spacing and rally hits, checked against a mode-level reference model.
module tb_pong_game_ctrl;
  import pong_game_ctrl_pkg::*;

  logic ClockK = 1'b0;
  logic reset  = 1'b0;
  int checks = 0;
  int errors = 0;
  int stray_ticks = 0;

  // Reference model: match mode as text, frames counted since mode entry / last tick.
  string mode = "IDLE";
  int m_p1 = 0, m_p2 = 0, m_div = DEF_SPEED_DIV, m_hits = 0, m_cnt = 0;
  bit m_win = 1'b0;

  pong_game_ctrl_if bus();

  pong_game_ctrl dut (
    .ClockK (ClockK),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 ClockK = ~ClockK;

  always @(posedge ClockK) begin
    if (bus.move_tick === 1'b1 && bus.frame_start !== 1'b1) stray_ticks++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":restart"},   32'(bus.restart),   32'(mode == "IDLE" || mode == "SERVE" || mode == "GAMEOVER"));
    check({tag, ":paused"},    32'(bus.paused),    32'(mode == "PAUSED"));
    check({tag, ":game_over"}, 32'(bus.game_over), 32'(mode == "GAMEOVER"));
    check({tag, ":point1"},    32'(bus.point1),    32'(m_p1));
    check({tag, ":point2"},    32'(bus.point2),    32'(m_p2));
    check({tag, ":winner"},    32'(bus.winner),    32'(m_win));
  endtask

  task automatic m_enter_serve();
    mode = "SERVE"; m_div = DEF_SPEED_DIV; m_hits = 0; m_cnt = 0;
  endtask

  task automatic m_frame(output bit tick);
    tick = 1'b0;
    if (mode == "SERVE") begin
      m_cnt++;
      if (m_cnt == DEF_SERVE_FRAMES) begin mode = "PLAY"; m_cnt = 0; end
    end else if (mode == "PLAY") begin
      m_cnt++;
      if (m_cnt >= m_div) begin tick = 1'b1; m_cnt = 0; end
    end else if (mode == "POINT") begin
      m_cnt++;
      if (m_cnt == DEF_POINT_FRAMES) m_enter_serve();
    end
  endtask

  task automatic m_press();
    if (mode == "IDLE") m_enter_serve();
    else if (mode == "PLAY") mode = "PAUSED";
    else if (mode == "PAUSED") mode = "PLAY";
    else if (mode == "GAMEOVER") begin m_p1 = 0; m_p2 = 0; m_enter_serve(); end
  endtask

  task automatic m_events(input bit g1, input bit g2, input bit h);
    if (mode != "PLAY") return;
    if (g1) begin
      m_p1++; m_cnt = 0;
      if (m_p1 == DEF_WIN_SCORE) begin mode = "GAMEOVER"; m_win = 1'b0; end
      else mode = "POINT";
    end else if (g2) begin
      m_p2++; m_cnt = 0;
      if (m_p2 == DEF_WIN_SCORE) begin mode = "GAMEOVER"; m_win = 1'b1; end
      else mode = "POINT";
    end else if (h) begin
      m_hits++;
      if (m_hits == DEF_ACCEL_HITS) begin
        m_hits = 0;
        m_div = (m_div - 1 < DEF_SPEED_MIN) ? DEF_SPEED_MIN : m_div - 1;
      end
    end
  endtask

  task automatic do_frame(input string tag, output bit ticked);
    bit exp_tick;
    bus.frame_start = 1'b1;
    #1;
    ticked = bus.move_tick;
    m_frame(exp_tick);
    check({tag, ":tick"}, 32'(ticked), 32'(exp_tick));
    @(negedge ClockK);
    bus.frame_start = 1'b0;
    check_outputs(tag);
    repeat ($urandom_range(0, 2)) @(negedge ClockK);
  endtask

  task automatic frames(input int n, input string tag, output int nticks, output bit last);
    bit t;
    nticks = 0; last = 1'b0;
    for (int i = 0; i < n; i++) begin
      do_frame(tag, t);
      if (t) nticks++;
      last = t;
    end
  endtask

  task automatic do_press(input string tag);
    bus.pause_btn = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge ClockK);
    bus.pause_btn = 1'b0;
    repeat (4) @(negedge ClockK);
    m_press();
    check_outputs(tag);
  endtask

  task automatic do_pulse(input bit g1, input bit g2, input bit h, input string tag);
    bus.goal1 = g1; bus.goal2 = g2; bus.hit = h;
    @(negedge ClockK);
    bus.goal1 = 1'b0; bus.goal2 = 1'b0; bus.hit = 1'b0;
    m_events(g1, g2, h);
    check_outputs(tag);
  endtask

  initial begin
    int  n;
    bit  last;
    bit  t;
    bus.frame_start = 1'b0; bus.pause_btn = 1'b0;
    bus.goal1 = 1'b0; bus.goal2 = 1'b0; bus.hit = 1'b0;

    repeat (3) @(negedge ClockK);
    check_outputs("reset");
    reset = 1'b1;
    repeat (20) @(negedge ClockK);
    check_outputs("idle");
    frames(3, "idle_frames", n, last);
    check("idle_no_tick", 32'(n), 32'd0);
    do_press("start");

    frames(DEF_SERVE_FRAMES, "serve", n, last);
    check("serve_no_tick", 32'(n), 32'd0);
    check("play_restart_low", 32'(bus.restart), 32'd0);
    frames(12, "first12", n, last);
    check("first12_count", 32'(n), 32'd1);
    check("first12_last", 32'(last), 32'd1);

    // Pause mid-count: 5 frames, pause 100 frames, resume -> tick on the 7th.
    frames(5, "pre_pause", n, last);
    do_press("pause");
    frames(50, "paused", n, last);
    check("paused_no_tick_a", 32'(n), 32'd0);
    do_pulse(1'b1, 1'b0, 1'b1, "paused_goal");
    frames(50, "paused", n, last);
    check("paused_no_tick_b", 32'(n), 32'd0);
    do_press("resume");
    frames(6, "resume6", n, last);
    check("resume6_count", 32'(n), 32'd0);
    do_frame("resume7", t);
    check("resume_7th", 32'(t), 32'd1);

    // Acceleration: 3 hits -> divider 11, then saturate at 4.
    for (int i = 0; i < 3; i++) do_pulse(1'b0, 1'b0, 1'b1, "hit");
    frames(22, "div11", n, last);
    check("div11_count", 32'(n), 32'd2);
    check("div11_last", 32'(last), 32'd1);
    for (int i = 0; i < 30; i++) do_pulse(1'b0, 1'b0, 1'b1, "hit_sat");
    t = 1'b0;
    for (int i = 0; i < 8 && !t; i++) do_frame("sync", t);
    check("sync_tick_seen", 32'(t), 32'd1);
    frames(20, "div4", n, last);
    check("div4_count", 32'(n), 32'd5);

    // Simultaneous goals: player 1 takes it.
    do_pulse(1'b1, 1'b1, 1'b0, "both_goals");
    check("both_p1", 32'(bus.point1), 32'd1);
    check("both_p2", 32'(bus.point2), 32'd0);
    frames(DEF_POINT_FRAMES, "point", n, last);
    check("point_no_tick", 32'(n), 32'd0);
    frames(DEF_SERVE_FRAMES, "serve2", n, last);
    frames(12, "reserve12", n, last);
    check("reserve12_count", 32'(n), 32'd1);
    check("reserve12_last", 32'(last), 32'd1);

    // Goal with hit same cycle, then rallies until player 2 has 8.
    do_pulse(1'b0, 1'b1, 1'b1, "goal_hit");
    frames(DEF_POINT_FRAMES, "point2", n, last);
    while (m_p2 < 8) begin
      frames(DEF_SERVE_FRAMES, "serve_r", n, last);
      for (int i = 0; i < $urandom_range(1, 15); i++) begin
        if ($urandom_range(0, 2) == 0) do_pulse(1'b0, 1'b0, 1'b1, "rally_hit");
        do_frame("rally", t);
      end
      do_pulse(1'b0, 1'b1, 1'b0, "goal2");
      frames(DEF_POINT_FRAMES, "point_r", n, last);
    end
    frames(DEF_SERVE_FRAMES, "serve_final", n, last);
    frames(3, "final_play", n, last);
    do_pulse(1'b0, 1'b1, 1'b0, "winning_goal");
    check("win_p2", 32'(bus.point2), 32'd9);
    check("win_game_over", 32'(bus.game_over), 32'd1);
    check("win_winner", 32'(bus.winner), 32'd1);
    frames(5, "gameover", n, last);
    check("gameover_no_tick", 32'(n), 32'd0);
    do_press("new_match");
    check("new_p1", 32'(bus.point1), 32'd0);
    check("new_p2", 32'(bus.point2), 32'd0);

    // Score one, then reset asynchronously in the middle of play.
    frames(DEF_SERVE_FRAMES, "serve_n", n, last);
    do_pulse(1'b1, 1'b0, 1'b0, "goal1_n");
    frames(DEF_POINT_FRAMES, "point_n", n, last);
    frames(DEF_SERVE_FRAMES, "serve_m", n, last);
    frames(4, "play_m", n, last);
    #2;
    reset = 1'b0;
    #1;
    mode = "IDLE"; m_p1 = 0; m_p2 = 0; m_win = 1'b0; m_div = DEF_SPEED_DIV; m_hits = 0; m_cnt = 0;
    check_outputs("async_reset");
    @(negedge ClockK);
    reset = 1'b1;
    frames(3, "after_reset", n, last);
    check("after_reset_no_tick", 32'(n), 32'd0);

    check("stray_ticks", 32'(stray_ticks), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
